// File: rtl/cpu_core.sv
`timescale 1ns/1ps
// cpu_core: WIDTH-bit accumulator CPU with carry/zero flags, conditional
// jumps, store, and a req/ack memory port that tolerates wait states.
// All memory-port outputs decode from registered state only, so mem_ack and
// mem_rdata never reach an output combinationally.
module cpu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             halted,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z
);

  typedef enum logic [2:0] {
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_ARG,
    ST_EXEC,
    ST_MEMRD,
    ST_MEMWR,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd10;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [3:0]       ir_reg, ir_next;     // only the opcode field is ever used
  logic [WIDTH-1:0] opr_reg, opr_next;
  logic             c_reg, c_next;
  logic             z_reg, z_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;

  assign add_sum  = {1'b0, acc_reg} + {1'b0, mem_rdata};
  assign sub_diff = acc_reg - mem_rdata;

  // State and architectural registers; reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_START;
      pc_reg        <= '0;
      acc_reg       <= '0;
      ir_reg        <= '0;
      opr_reg       <= '0;
      c_reg         <= 1'b0;
      z_reg         <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      acc_reg       <= acc_next;
      ir_reg        <= ir_next;
      opr_reg       <= opr_next;
      c_reg         <= c_next;
      z_reg         <= z_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Next-state and datapath updates; everything holds unless a state acts.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    acc_next       = acc_reg;
    ir_next        = ir_reg;
    opr_next       = opr_reg;
    c_next         = c_reg;
    z_next         = z_reg;
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;

    case (state_reg)
      ST_START: state_next = ST_FETCH;

      ST_FETCH: begin
        if (mem_ack) begin
          ir_next    = mem_rdata[3:0];
          pc_next    = pc_reg + PC_STEP;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (ir_reg)
          OP_OUT: begin
            out_data_next  = acc_reg;
            out_valid_next = 1'b1;
            state_next     = ST_FETCH;
          end
          OP_HLT: state_next = ST_HALT;
          OP_LDA, OP_ADD, OP_SUB, OP_STA,
          OP_LDI, OP_JMP, OP_JC, OP_JZ: state_next = ST_ARG;
          default: state_next = ST_FETCH;
        endcase
      end

      ST_ARG: begin
        if (mem_ack) begin
          opr_next   = mem_rdata;
          pc_next    = pc_reg + PC_STEP;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_next = ST_FETCH;
        case (ir_reg)
          OP_LDI: acc_next = opr_reg;
          OP_JMP: pc_next = opr_reg;
          OP_JC:  if (c_reg) pc_next = opr_reg;
          OP_JZ:  if (z_reg) pc_next = opr_reg;
          OP_LDA, OP_ADD, OP_SUB: state_next = ST_MEMRD;
          OP_STA: state_next = ST_MEMWR;
          default: state_next = ST_FETCH;
        endcase
      end

      ST_MEMRD: begin
        if (mem_ack) begin
          state_next = ST_FETCH;
          case (ir_reg)
            OP_ADD: begin
              acc_next = add_sum[WIDTH-1:0];
              c_next   = add_sum[WIDTH];
              z_next   = (add_sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
              acc_next = sub_diff;
              c_next   = (acc_reg >= mem_rdata);
              z_next   = (sub_diff == '0);
            end
            default: begin
              acc_next = mem_rdata;
              z_next   = (mem_rdata == '0);
            end
          endcase
        end
      end

      ST_MEMWR: begin
        if (mem_ack) state_next = ST_FETCH;
      end

      ST_HALT: state_next = ST_HALT;

      default: state_next = ST_START;
    endcase
  end

  // Memory port decoded purely from registered state.
  assign mem_req   = (state_reg == ST_FETCH) || (state_reg == ST_ARG) ||
                     (state_reg == ST_MEMRD) || (state_reg == ST_MEMWR);
  assign mem_we    = (state_reg == ST_MEMWR);
  assign mem_addr  = ((state_reg == ST_MEMRD) || (state_reg == ST_MEMWR)) ? opr_reg : pc_reg;
  assign mem_wdata = acc_reg;

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign halted    = (state_reg == ST_HALT);
  assign pc        = pc_reg;
  assign acc       = acc_reg;
  assign flag_c    = c_reg;
  assign flag_z    = z_reg;

endmodule
